de2i_150_qsys_nios2_qsys_oci_dct_packer: RTL and testbench

- Sequences the Nios II OCI direct-control-transfer (DCT) trace buffer: packs 2-bit branch-outcome codes into a 30-bit buffer with a 4-bit occupancy count.
- Launches full or partial buffers as trace frames over a valid/ready handshake.
- Drives the end-of-test drain that the OCI test bench monitors via dct_buffer, dct_count, test_ending and test_has_ended.

---
 rtl/de2i_150_qsys_nios2_qsys_oci_dct_packer.sv | 121 ++++++++++++
 tb/tb_de2i_150_qsys_nios2_qsys_oci_dct_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de2i_150_qsys_nios2_qsys_oci_dct_packer.sv
// OCI DCT trace packer: collects 2-bit branch codes into a 30-bit buffer
// and launches full/partial trace frames; handles the end-of-test drain.
module de2i_150_qsys_nios2_qsys_oci_dct_packer #(
  parameter int unsigned MAX_ENTRIES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trace_enable,
  input  logic        dct_in_valid,
  input  logic [1:0]  dct_in_code,
  input  logic        flush_req,
  input  logic        test_ending,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [35:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [7:0]  drop_count,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    RUN,
    ENDING,
    ENDED
  } state_e;

  localparam logic [3:0] MAXC = 4'(MAX_ENTRIES);

  state_e      state_q, state_d;
  logic [29:0] dbuf_q, dbuf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fvalid_q, fvalid_d;
  logic [35:0] fdata_q, fdata_d;
  logic        flush_q, flush_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drop_q, drop_d;

  logic        frame_free, full, flush_want;
  logic        launch, accept, drop;
  logic [3:0]  base_cnt;

  always_comb begin
    frame_free = !fvalid_q | frame_ready;
    full       = cnt_q == MAXC;
    flush_want = flush_q | (state_q == ENDING);
    launch     = frame_free &
                 (full | (flush_want & (cnt_q != 4'd0)));
    // the code sampled with test_ending is already past the cut-off
    accept     = dct_in_valid & trace_enable &
                 (state_q == RUN) & !test_ending;

    dbuf_d   = launch ? 30'd0 : dbuf_q;
    base_cnt = launch ? 4'd0 : cnt_q;
    cnt_d    = base_cnt;
    drop     = accept & (base_cnt == MAXC);
    if (accept && !drop) begin
      for (int i = 0; i < 15; i++) begin
        if (base_cnt == 4'(i)) dbuf_d[2*i +: 2] = dct_in_code;
      end
      cnt_d = base_cnt + 4'd1;
    end

    fvalid_d = fvalid_q;
    fdata_d  = fdata_q;
    if (launch) begin
      fvalid_d = 1'b1;
      fdata_d  = {full ? 2'b01 : 2'b10, cnt_q, dbuf_q};
    end else if (frame_ready) begin
      fvalid_d = 1'b0;
    end

    flush_d = flush_req |
              (flush_q & !launch & (cnt_q != 4'd0));

    ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    state_d = state_q;
    case (state_q)
      RUN:     if (test_ending) state_d = ENDING;
      ENDING:  if (cnt_q == 4'd0 && !fvalid_q && !flush_q)
                 state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      dbuf_q   <= '0;
      cnt_q    <= '0;
      fvalid_q <= 1'b0;
      fdata_q  <= '0;
      flush_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      dbuf_q   <= dbuf_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fvalid_d;
      fdata_q  <= fdata_d;
      flush_q  <= flush_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign frame_valid    = fvalid_q;
  assign frame_data     = fdata_q;
  assign dct_buffer     = dbuf_q;
  assign dct_count      = cnt_q;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;
  assign test_has_ended = state_q == ENDED;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_qsys_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_de2i_150_qsys_nios2_qsys_oci_dct_packer;

  localparam int MAXE = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        trace_enable = 1'b1;
  logic        dct_in_valid = 1'b0;
  logic [1:0]  dct_in_code = 2'd0;
  logic        flush_req = 1'b0;
  logic        test_ending = 1'b0;
  logic        frame_ready = 1'b0;
  logic        overflow_clr = 1'b0;
  logic        frame_valid;
  logic [35:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        test_has_ended;

  de2i_150_qsys_nios2_qsys_oci_dct_packer #(.MAX_ENTRIES(MAXE)) dut (
    .clk(clk), .reset_n(reset_n), .trace_enable(trace_enable),
    .dct_in_valid(dct_in_valid), .dct_in_code(dct_in_code),
    .flush_req(flush_req), .test_ending(test_ending),
    .frame_ready(frame_ready), .frame_valid(frame_valid),
    .frame_data(frame_data), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_count(drop_count),
    .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  int unsigned npass = 0;
  int unsigned ntotal = 0;
  bit          chk_en = 0;
  logic [35:0] gotq[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ntotal++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      npass++;
  endtask

  // reference model: codes held in a queue, frame as a plain value
  logic [1:0]  mq[$];
  bit          mfv = 0;
  logic [35:0] mfd = '0;
  bit          mfp = 0;
  bit          movf = 0;
  int          mdrop = 0;
  int          mst = 0;

  function automatic logic [29:0] pack();
    logic [29:0] r = '0;
    foreach (mq[i]) r = r | (30'(mq[i]) << (2 * i));
    return r;
  endfunction

  task automatic mstep();
    bit free, full, launch, acc;
    int n;
    n      = mq.size();
    free   = !mfv || frame_ready;
    full   = n == MAXE;
    launch = free && (full || ((mfp || mst == 1) && n > 0));
    acc    = dct_in_valid && trace_enable && mst == 0 && !test_ending;
    if (mst == 0 && test_ending) mst = 1;
    else if (mst == 1 && n == 0 && !mfv && !mfp) mst = 2;
    mfp = flush_req || (mfp && !launch && n > 0);
    if (launch) begin
      mfd = {full ? 2'b01 : 2'b10, 4'(n), pack()};
      mfv = 1;
      mq.delete();
    end else if (frame_ready) mfv = 0;
    if (acc && mq.size() == MAXE) begin
      movf = 1;
      if (mdrop < 255) mdrop++;
    end else begin
      if (acc) mq.push_back(dct_in_code);
      if (overflow_clr) movf = 0;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mfv = 0; mfd = '0; mfp = 0; movf = 0; mdrop = 0; mst = 0;
    end else mstep();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("frame_valid", 64'(frame_valid), 64'(mfv));
      if (mfv) chk("frame_data", 64'(frame_data), 64'(mfd));
      chk("dct_buffer", 64'(dct_buffer), 64'(pack()));
      chk("dct_count", 64'(dct_count), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("drop_count", 64'(drop_count), 64'(mdrop));
      chk("test_has_ended", 64'(test_has_ended), 64'(mst == 2));
    end
    if (reset_n && frame_valid && frame_ready) gotq.push_back(frame_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c);
    dct_in_valid = 1'b1;
    dct_in_code  = c;
    tick();
    dct_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst frame_valid", 64'(frame_valid), 64'd0);
    chk("rst dct_count", 64'(dct_count), 64'd0);
    chk("rst ended", 64'(test_has_ended), 64'd0);
    chk_en = 1;
    tick();
    tick();
    reset_n = 1'b1;
    frame_ready = 1'b1;

    // full frame of 0,1,2,3,...
    gotq.delete();
    for (int i = 0; i < 15; i++) push(2'(i % 4));
    idle(5);
    chk("full n", 64'(gotq.size()), 64'd1);
    if (gotq.size() > 0)
      chk("full data", 64'(gotq[0]), 64'({2'b01, 4'hF, 30'h24E4E4E4}));
    chk("full cnt after", 64'(dct_count), 64'd0);

    // partial flush, then flush of an empty buffer
    gotq.delete();
    for (int i = 0; i < 5; i++) push(2'b11);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(5);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(5);
    chk("part n", 64'(gotq.size()), 64'd1);
    if (gotq.size() > 0)
      chk("part data", 64'(gotq[0]), 64'({2'b10, 4'h5, 30'h3FF}));

    // backpressure with overflow
    gotq.delete();
    frame_ready = 1'b0;
    for (int i = 0; i < 33; i++) push(2'(i % 4));
    chk("bp cnt", 64'(dct_count), 64'd15);
    chk("bp ovf", 64'(overflow), 64'd1);
    chk("bp drops", 64'(drop_count), 64'd3);
    frame_ready = 1'b1;
    idle(3);
    chk("bp n", 64'(gotq.size()), 64'd2);
    if (gotq.size() > 1) begin
      chk("bp f1", 64'(gotq[0]), 64'({2'b01, 4'hF, 30'h24E4E4E4}));
      chk("bp f2", 64'(gotq[1]), 64'({2'b01, 4'hF, 30'h13939393}));
    end
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("clr ovf", 64'(overflow), 64'd0);
    chk("clr drops", 64'(drop_count), 64'd3);

    // trace disabled
    gotq.delete();
    for (int i = 0; i < 3; i++) push(2'd2);
    trace_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin push(2'd1); tick(); end
    chk("dis cnt", 64'(dct_count), 64'd3);
    chk("dis drops", 64'(drop_count), 64'd3);
    chk("dis frames", 64'(gotq.size()), 64'd0);
    trace_enable = 1'b1;

    // async reset mid-buffer with a held frame
    frame_ready = 1'b0;
    for (int i = 0; i < 21; i++) push(2'd1);
    chk("pre-rst cnt", 64'(dct_count), 64'd9);
    chk("pre-rst fv", 64'(frame_valid), 64'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async fv", 64'(frame_valid), 64'd0);
    chk("async fd", 64'(frame_data), 64'd0);
    chk("async buf", 64'(dct_buffer), 64'd0);
    chk("async cnt", 64'(dct_count), 64'd0);
    chk("async drops", 64'(drop_count), 64'd0);
    tick();
    reset_n = 1'b1;
    frame_ready = 1'b1;
    push(2'd3); push(2'd2);
    chk("resume cnt", 64'(dct_count), 64'd2);
    chk("resume buf", 64'(dct_buffer), 64'h0B);

    // drop counter saturation, set beats clear
    frame_ready = 1'b0;
    for (int i = 0; i < 300; i++) push(2'(i));
    chk("sat drops", 64'(drop_count), 64'd255);
    overflow_clr = 1'b1; push(2'd0); overflow_clr = 1'b0;
    chk("set wins", 64'(overflow), 64'd1);
    frame_ready = 1'b1;
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      dct_in_valid = $urandom_range(0, 3) != 0;
      dct_in_code  = 2'($urandom);
      trace_enable = $urandom_range(0, 7) != 0;
      flush_req    = $urandom_range(0, 15) == 0;
      frame_ready  = $urandom_range(0, 2) != 0;
      overflow_clr = $urandom_range(0, 31) == 0;
      tick();
    end
    dct_in_valid = 1'b0; flush_req = 1'b0; overflow_clr = 1'b0;
    trace_enable = 1'b1; frame_ready = 1'b1;
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    idle(10);

    // end-of-test drain
    gotq.delete();
    for (int i = 0; i < 7; i++) push(2'd1);
    test_ending = 1'b1;
    push(2'd3);
    for (int k = 0; k < 40 && !test_has_ended; k++) tick();
    chk("end frames", 64'(gotq.size()), 64'd1);
    if (gotq.size() > 0)
      chk("end frame", 64'(gotq[0]), 64'({2'b10, 4'd7, 30'h1555}));
    chk("end flag", 64'(test_has_ended), 64'd1);
    test_ending = 1'b0;
    idle(3);
    chk("end sticky", 64'(test_has_ended), 64'd1);

    chk_en = 0;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
